// File: rtl/sdrc_req_arb_if.sv
// Bundle of the four requester ports and the single SDRAM controller port around sdrc_req_arb.
// The arbiter connects through slave; requesters and the controller side connect through master.
interface sdrc_req_arb_if #(
    parameter int dw = 32,
    parameter int bl = 9
);
    // requester side, four ports packed side by side
    logic [3:0]          req_i;
    logic [4*30-1:0]     req_addr_i;
    logic [4*bl-1:0]     req_len_i;
    logic [3:0]          req_wr_n_i;
    logic [3:0]          req_ack_o;
    logic [4*dw/8-1:0]   wr_en_n_i;
    logic [4*dw-1:0]     wr_data_i;
    logic [3:0]          wr_next_o;
    logic [3:0]          rd_valid_o;
    logic [3:0]          last_rd_o;
    logic [dw-1:0]       rd_data_o;

    // controller side
    logic                sdr_req;
    logic [29:0]         sdr_req_addr;
    logic [bl-1:0]       sdr_req_len;
    logic                sdr_req_wr_n;
    logic                sdr_req_ack;
    logic                sdr_busy_n;
    logic [dw/8-1:0]     sdr_wr_en_n;
    logic [dw-1:0]       sdr_wr_data;
    logic                sdr_wr_next;
    logic                sdr_rd_valid;
    logic                sdr_last_rd;
    logic [dw-1:0]       sdr_rd_data;

    modport slave (
        input  req_i, req_addr_i, req_len_i, req_wr_n_i, wr_en_n_i, wr_data_i,
        output req_ack_o, wr_next_o, rd_valid_o, last_rd_o, rd_data_o,
        output sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n, sdr_wr_en_n, sdr_wr_data,
        input  sdr_req_ack, sdr_busy_n, sdr_wr_next, sdr_rd_valid, sdr_last_rd, sdr_rd_data
    );

    modport master (
        output req_i, req_addr_i, req_len_i, req_wr_n_i, wr_en_n_i, wr_data_i,
        input  req_ack_o, wr_next_o, rd_valid_o, last_rd_o, rd_data_o,
        input  sdr_req, sdr_req_addr, sdr_req_len, sdr_req_wr_n, sdr_wr_en_n, sdr_wr_data,
        output sdr_req_ack, sdr_busy_n, sdr_wr_next, sdr_rd_valid, sdr_last_rd, sdr_rd_data
    );
endinterface

// File: rtl/sdrc_req_arb.sv
// Four-port round-robin arbiter in front of the SDRAM controller: one transaction at a time,
// command, write beats and read beats steered combinationally to the granted port.
module sdrc_req_arb #(
    parameter int dw = 32,
    parameter int bl = 9
) (
    input  logic         sdram_clk,
    input  logic         sdram_resetn,
    sdrc_req_arb_if.slave bus,
    output logic [1:0]   gnt_o,
    output logic         busy_o,
    output logic         protocol_err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WR_DATA = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      gnt;
    logic [1:0]      last_gnt;
    logic [bl-1:0]   cnt;

    logic            arb_hit;
    logic [1:0]      arb_win;
    logic [1:0]      cand;

    logic            sel_req;
    logic [29:0]     sel_addr;
    logic [bl-1:0]   sel_len;
    logic            sel_wr_n;

    logic            arb_fire;
    logic            ack_fire;
    logic            wr_last;

    always_comb begin
        sel_req  = bus.req_i[gnt];
        sel_addr = bus.req_addr_i[32'(gnt)*30 +: 30];
        sel_len  = bus.req_len_i[32'(gnt)*bl +: bl];
        sel_wr_n = bus.req_wr_n_i[gnt];
    end

    // Search order last_gnt+1, +2, +3, then last_gnt itself.
    always_comb begin
        arb_hit = 1'b0;
        arb_win = last_gnt;
        cand    = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_gnt + 2'(i);
            if (!arb_hit && bus.req_i[cand]) begin
                arb_hit = 1'b1;
                arb_win = cand;
            end
        end
    end

    assign arb_fire = (state == IDLE) && bus.sdr_busy_n && arb_hit;
    assign ack_fire = (state == REQ) && bus.sdr_req_ack;
    assign wr_last  = bus.sdr_wr_next && (cnt == bl'(1));

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack coinciding with the request falling still starts the transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_fire) state_nxt = REQ;
            REQ: begin
                if (bus.sdr_req_ack) begin
                    state_nxt = sel_wr_n ? RD_DATA : WR_DATA;
                end else if (!sel_req) begin
                    state_nxt = IDLE;
                end
            end
            WR_DATA: if (wr_last) state_nxt = IDLE;
            RD_DATA: if (bus.sdr_rd_valid && bus.sdr_last_rd) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            gnt      <= '0;
            last_gnt <= 2'd3;
            cnt      <= '0;
        end else begin
            if (arb_fire) begin
                gnt <= arb_win;
            end
            if (ack_fire) begin
                last_gnt <= gnt;
                cnt      <= (sel_len == '0) ? bl'(1) : sel_len;
            end else if ((state == WR_DATA) && bus.sdr_wr_next && (cnt != '0)) begin
                cnt <= cnt - bl'(1);
            end
        end
    end

    always_comb begin
        bus.req_ack_o    = '0;
        bus.wr_next_o    = '0;
        bus.rd_valid_o   = '0;
        bus.last_rd_o    = '0;
        bus.sdr_req      = 1'b0;
        bus.sdr_req_addr = '0;
        bus.sdr_req_len  = '0;
        bus.sdr_req_wr_n = 1'b1;
        bus.sdr_wr_en_n  = '1;
        bus.sdr_wr_data  = '0;
        case (state)
            REQ: begin
                bus.sdr_req        = sel_req;
                bus.sdr_req_addr   = sel_addr;
                bus.sdr_req_len    = sel_len;
                bus.sdr_req_wr_n   = sel_wr_n;
                bus.req_ack_o[gnt] = bus.sdr_req_ack;
            end
            WR_DATA: begin
                bus.sdr_wr_en_n    = bus.wr_en_n_i[32'(gnt)*(dw/8) +: dw/8];
                bus.sdr_wr_data    = bus.wr_data_i[32'(gnt)*dw +: dw];
                bus.wr_next_o[gnt] = bus.sdr_wr_next;
            end
            RD_DATA: begin
                bus.rd_valid_o[gnt] = bus.sdr_rd_valid;
                bus.last_rd_o[gnt]  = bus.sdr_rd_valid && bus.sdr_last_rd;
            end
            default: ;
        endcase
    end

    assign bus.rd_data_o = bus.sdr_rd_data;
    assign gnt_o         = gnt;
    assign busy_o        = (state != IDLE);
    assign protocol_err_o = (bus.sdr_wr_next  && (state != WR_DATA))
                         || (bus.sdr_rd_valid && (state != RD_DATA))
                         || (bus.sdr_req_ack  && (state != REQ));

endmodule

// File: tb/tb_sdrc_req_arb.sv
// Directed bench for sdrc_req_arb: stimulus pushes expected strobes into a queue, a negedge
// monitor pops and compares whenever the arbiter presents an ack, data strobe or error pulse.
module tb_sdrc_req_arb;
    localparam int DW = 32;
    localparam int BL = 9;
    localparam int K_ACK = 0, K_WR = 1, K_RD = 2, K_ERR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdrc_req_arb_if #(.dw(DW), .bl(BL)) bus ();
    logic [1:0] gnt;
    logic       busy;
    logic       perr;

    sdrc_req_arb #(.dw(DW), .bl(BL)) dut (
        .sdram_clk      (clk),
        .sdram_resetn   (rst_n),
        .bus            (bus),
        .gnt_o          (gnt),
        .busy_o         (busy),
        .protocol_err_o (perr)
    );

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] data;
        logic [3:0]  en;
        logic [8:0]  len;
        logic        wr_n;
        logic        last;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [29:0] addr_of(input int p);
        return 30'h0ABC_0000 + 30'(p * 17);
    endfunction
    function automatic logic [31:0] wdat(input int p, input int b);
        return 32'hD000_0000 ^ 32'(p << 16) ^ 32'(b * 5 + 1);
    endfunction
    function automatic logic [3:0] wen(input int p, input int b);
        return 4'(p * 3 + b + 1);
    endfunction
    function automatic logic [31:0] rdat(input int p, input int b);
        return 32'h5EED_0000 ^ 32'(p << 8) ^ 32'(b);
    endfunction

    // Monitor: every strobe the arbiter presents must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.req_ack_o != 4'b0 || bus.wr_next_o != 4'b0 || bus.rd_valid_o != 4'b0 || perr) begin
            if (q.size() == 0) begin
                chk("unexpected_strobe", 64'({bus.req_ack_o, bus.wr_next_o, bus.rd_valid_o, perr}), 64'd0);
            end else begin
                e = q.pop_front();
                case (e.kind)
                    K_ACK: begin
                        chk("ack_port", 64'(bus.req_ack_o), 64'(4'b0001 << e.port));
                        chk("ack_addr", 64'(bus.sdr_req_addr), 64'(e.data));
                        chk("ack_len", 64'(bus.sdr_req_len), 64'(e.len));
                        chk("ack_wr_n", 64'(bus.sdr_req_wr_n), 64'(e.wr_n));
                        chk("ack_gnt", 64'(gnt), 64'(e.port));
                    end
                    K_WR: begin
                        chk("wr_port", 64'(bus.wr_next_o), 64'(4'b0001 << e.port));
                        chk("wr_data", 64'(bus.sdr_wr_data), 64'(e.data));
                        chk("wr_en", 64'(bus.sdr_wr_en_n), 64'(e.en));
                    end
                    K_RD: begin
                        chk("rd_port", 64'(bus.rd_valid_o), 64'(4'b0001 << e.port));
                        chk("rd_last", 64'(bus.last_rd_o), e.last ? 64'(4'b0001 << e.port) : 64'd0);
                        chk("rd_data", 64'(bus.rd_data_o), 64'(e.data));
                    end
                    default: begin
                        chk("err_flag", 64'(perr), 64'd1);
                        chk("err_no_strobe",
                            64'({bus.req_ack_o, bus.wr_next_o, bus.rd_valid_o, bus.last_rd_o}), 64'd0);
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int p, input logic [31:0] d, input logic [3:0] en,
                        input logic [8:0] len, input logic wr_n, input logic last);
        exp_t e;
        e.kind = kind; e.port = p; e.data = d; e.en = en; e.len = len; e.wr_n = wr_n; e.last = last;
        q.push_back(e);
    endtask

    task automatic set_cmd(input int p, input logic wr_n, input logic [8:0] len);
        bus.req_wr_n_i[p] = wr_n;
        bus.req_len_i[p*BL +: BL] = len;
    endtask

    task automatic grant_ack(input int p, input bit keep);
        int k;
        for (k = 0; k < 20 && !bus.sdr_req; k++) step();
        if (!bus.sdr_req) chk("sdr_req_timeout", 64'd0, 64'd1);
        chk("grant_port", 64'(gnt), 64'(p));
        push(K_ACK, p, 32'(addr_of(p)), 4'h0, bus.req_len_i[p*BL +: BL], bus.req_wr_n_i[p], 1'b0);
        bus.sdr_req_ack = 1'b1;
        step();
        bus.sdr_req_ack = 1'b0;
        if (!keep) bus.req_i[p] = 1'b0;
    endtask

    task automatic wr_beats(input int p, input int n);
        for (int b = 0; b < n; b++) begin
            for (int r = 0; r < 4; r++) begin
                bus.wr_data_i[r*DW +: DW]     = (r == p) ? wdat(r, b) : ~wdat(r, b);
                bus.wr_en_n_i[r*4 +: 4]       = (r == p) ? wen(r, b) : ~wen(r, b);
            end
            push(K_WR, p, wdat(p, b), wen(p, b), 9'd0, 1'b0, 1'b0);
            bus.sdr_wr_next = 1'b1;
            step();
        end
        bus.sdr_wr_next = 1'b0;
    endtask

    task automatic rd_beats(input int p, input int n);
        for (int b = 0; b < n; b++) begin
            bus.sdr_rd_data  = rdat(p, b);
            bus.sdr_rd_valid = 1'b1;
            bus.sdr_last_rd  = (b == n - 1);
            push(K_RD, p, rdat(p, b), 4'h0, 9'd0, 1'b0, b == n - 1);
            step();
        end
        bus.sdr_rd_valid = 1'b0;
        bus.sdr_last_rd  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        bus.req_i = '0; bus.req_len_i = '0; bus.req_wr_n_i = '1;
        bus.wr_en_n_i = '1; bus.wr_data_i = '0;
        bus.sdr_req_ack = 1'b0; bus.sdr_busy_n = 1'b1; bus.sdr_wr_next = 1'b0;
        bus.sdr_rd_valid = 1'b0; bus.sdr_last_rd = 1'b0; bus.sdr_rd_data = '0;
        for (int p = 0; p < 4; p++) bus.req_addr_i[p*30 +: 30] = addr_of(p);

        // reset values, with requests pending that must stay ungranted
        bus.req_i = 4'hF;
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_sdr_req", 64'({bus.sdr_req, bus.sdr_req_addr, bus.sdr_req_len, bus.sdr_req_wr_n}), 64'd1);
        chk("rst_wr_idle", 64'({bus.sdr_wr_en_n, bus.sdr_wr_data}), 64'({4'hF, 32'h0}));
        chk("rst_port_out", 64'({bus.req_ack_o, bus.wr_next_o, bus.rd_valid_o, bus.last_rd_o, perr}), 64'd0);
        bus.req_i = 4'h0;
        step();
        rst_n = 1'b1;
        step();

        // port 0 write, len 4, back-to-back beats
        set_cmd(0, 1'b0, 9'd4);
        bus.req_i[0] = 1'b1;
        step();
        chk("req_latency", 64'(bus.sdr_req), 64'd1);
        grant_ack(0, 1'b0);
        wr_beats(0, 4);
        chk("wr4_busy_done", 64'(busy), 64'd0);
        chk("wr4_idle_bus", 64'({bus.sdr_wr_en_n, bus.sdr_wr_data}), 64'({4'hF, 32'h0}));

        // all four ports read len 1 together from reset
        do_reset();
        for (int p = 0; p < 4; p++) set_cmd(p, 1'b1, 9'd1);
        bus.req_i = 4'hF;
        for (int p = 0; p < 4; p++) begin
            grant_ack(p, 1'b0);
            rd_beats(p, 1);
        end

        // ports 1 and 3 held continuously with last_gnt=1
        do_reset();
        set_cmd(1, 1'b1, 9'd2);
        set_cmd(3, 1'b1, 9'd2);
        bus.req_i[1] = 1'b1;
        grant_ack(1, 1'b0);
        rd_beats(1, 2);
        bus.req_i = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            grant_ack((k % 2 == 0) ? 3 : 1, 1'b1);
            rd_beats((k % 2 == 0) ? 3 : 1, 2);
        end
        bus.req_i = 4'h0;

        // controller busy holds off arbitration; port 2 withdraws before ack
        bus.sdr_busy_n = 1'b0;
        set_cmd(2, 1'b0, 9'd0);
        bus.req_i[2] = 1'b1;
        step();
        step();
        chk("busy_n_hold", 64'({bus.sdr_req, busy}), 64'd0);
        bus.sdr_busy_n = 1'b1;
        step();
        chk("drop_gnt", 64'({bus.sdr_req, gnt}), 64'({1'b1, 2'd2}));
        step();
        chk("drop_still_req", 64'(busy), 64'd1);
        bus.req_i[2] = 1'b0;
        step();
        chk("drop_to_idle", 64'(busy), 64'd0);
        set_cmd(0, 1'b1, 9'd1);
        bus.req_i = 4'b0101;
        grant_ack(2, 1'b0);
        wr_beats(2, 1);
        chk("len0_one_beat", 64'(busy), 64'd0);
        grant_ack(0, 1'b0);
        rd_beats(0, 1);

        // stray strobes: rd_valid and req_ack in IDLE, wr_next during RD_DATA
        bus.sdr_rd_data  = 32'hBAD0_0001;
        bus.sdr_rd_valid = 1'b1;
        push(K_ERR, 0, 32'h0, 4'h0, 9'd0, 1'b0, 1'b0);
        step();
        bus.sdr_rd_valid = 1'b0;
        chk("stray_rd_idle", 64'(busy), 64'd0);
        bus.sdr_req_ack = 1'b1;
        push(K_ERR, 0, 32'h0, 4'h0, 9'd0, 1'b0, 1'b0);
        step();
        bus.sdr_req_ack = 1'b0;
        chk("stray_ack_idle", 64'(busy), 64'd0);
        set_cmd(1, 1'b1, 9'd3);
        bus.req_i[1] = 1'b1;
        grant_ack(1, 1'b0);
        bus.sdr_wr_next = 1'b1;
        push(K_ERR, 0, 32'h0, 4'h0, 9'd0, 1'b0, 1'b0);
        step();
        bus.sdr_wr_next = 1'b0;
        chk("stray_wr_in_rd", 64'(busy), 64'd1);
        rd_beats(1, 3);
        chk("rd3_done", 64'(busy), 64'd0);

        // reset in the middle of an 8-beat write
        set_cmd(0, 1'b0, 9'd8);
        bus.req_i[0] = 1'b1;
        grant_ack(0, 1'b0);
        wr_beats(0, 2);
        chk("mid_wr_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_state", 64'({busy, gnt, perr}), 64'd0);
        chk("abort_bus", 64'({bus.sdr_req, bus.sdr_wr_en_n, bus.sdr_wr_data}), 64'({1'b0, 4'hF, 32'h0}));
        chk("abort_ports", 64'({bus.req_ack_o, bus.wr_next_o, bus.rd_valid_o, bus.last_rd_o}), 64'd0);
        step();
        rst_n = 1'b1;
        set_cmd(0, 1'b1, 9'd1);
        set_cmd(3, 1'b1, 9'd1);
        bus.req_i = 4'b1001;
        grant_ack(0, 1'b0);
        rd_beats(0, 1);
        grant_ack(3, 1'b0);
        rd_beats(3, 1);

        step();
        step();
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
